// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, master FSM states and command helpers.
package ahb_pkg;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned BEATS_W = 5;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_BURST,
    ST_LASTDATA,
    ST_ERR,
    ST_REJECT
  } mst_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              write;
    logic [1:0]        len;
  } cmd_t;

  function automatic logic [BEATS_W-1:0] len_to_beats(input logic [1:0] len);
    case (len)
      2'b00:   return BEATS_W'(1);
      2'b01:   return BEATS_W'(4);
      2'b10:   return BEATS_W'(8);
      default: return BEATS_W'(16);
    endcase
  endfunction

  function automatic logic [2:0] len_to_hburst(input logic [1:0] len);
    case (len)
      2'b00:   return HBURST_SINGLE;
      2'b01:   return HBURST_INCR4;
      2'b10:   return HBURST_INCR8;
      default: return HBURST_INCR16;
    endcase
  endfunction

endpackage

// File: rtl/ahb_burst_addr_gen.sv
// Burst address generator: start address, +4 per accepted beat, first/last flags
// and a 1KB boundary check on the command being loaded.
module ahb_burst_addr_gen
  import ahb_pkg::*;
(
  input  logic               HCLK,
  input  logic               HRESETn,
  input  logic               load,
  input  logic [ADDR_W-1:0]  load_addr,
  input  logic [BEATS_W-1:0] load_beats,
  input  logic               advance,
  output logic [ADDR_W-1:0]  addr,
  output logic               first_c,
  output logic               last_c,
  output logic               cross_c
);

  localparam int unsigned SPAN_W = 12;

  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  last_idx_q;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      addr_q     <= '0;
      cnt_q      <= '0;
      last_idx_q <= '0;
    end else if (load) begin
      addr_q     <= load_addr;
      cnt_q      <= '0;
      last_idx_q <= CNT_W'(load_beats - BEATS_W'(1));
    end else if (advance) begin
      addr_q <= addr_q + ADDR_W'(4);
      cnt_q  <= cnt_q + CNT_W'(1);
    end
  end

  assign addr    = addr_q;
  assign first_c = (cnt_q == '0);
  assign last_c  = (cnt_q == last_idx_q);
  // End of burst may touch the 1KB line but not pass it.
  assign cross_c = (SPAN_W'(load_addr[9:0]) + SPAN_W'({load_beats, 2'b00})) > SPAN_W'(1024);

endmodule

// File: rtl/ahb_lite_master.sv
// AHB-Lite initiator: turns single commands into pipelined SINGLE/INCR4/8/16
// word transfers with wait-state and ERROR response handling.
module ahb_lite_master
  import ahb_pkg::*;
#(
  parameter logic [3:0] HPROT_VAL = 4'b0011,
  parameter logic       LOCKED    = 1'b0
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic              cmd_write,
  input  logic [1:0]        cmd_len,
  input  logic [DATA_W-1:0] wdata,
  output logic              wdata_pop,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              done,
  output logic              done_err,
  output logic              busy,
  output logic [ADDR_W-1:0] HADDR,
  output logic [2:0]        HBURST,
  output logic              HMASTLOCK,
  output logic [3:0]        HPROT,
  output logic [2:0]        HSIZE,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [DATA_W-1:0] HWDATA,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HREADY,
  input  logic              HRESP
);

  cmd_t               cmd;
  logic [BEATS_W-1:0] cmd_beats;

  mst_state_t        state_q, state_d;
  logic [1:0]        htrans_q, htrans_d;
  logic              hwrite_q, hwrite_d;
  logic [2:0]        hburst_q, hburst_d;
  logic [DATA_W-1:0] hwdata_q, hwdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rdata_valid_q, rdata_valid_d;
  logic              done_q, done_d;
  logic              done_err_q, done_err_d;
  logic              busy_q, busy_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              discard_q, discard_d;

  logic              gen_load, gen_adv;
  logic [ADDR_W-1:0] gen_addr;
  logic              gen_first_c, gen_last_c, gen_cross_c;
  logic              wdata_pop_c;
  logic              in_addr_c, dp_c, err_c, good_rd_c, reject_c;

  assign cmd       = '{addr: cmd_addr, write: cmd_write, len: cmd_len};
  assign cmd_beats = len_to_beats(cmd.len);

  ahb_burst_addr_gen u_addr_gen (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .load       (gen_load),
    .load_addr  (cmd.addr),
    .load_beats (cmd_beats),
    .advance    (gen_adv),
    .addr       (gen_addr),
    .first_c    (gen_first_c),
    .last_c     (gen_last_c),
    .cross_c    (gen_cross_c)
  );

  // A data phase is in flight whenever an earlier address of this command was accepted.
  assign in_addr_c = (state_q == ST_ADDR) || (state_q == ST_BURST);
  assign dp_c      = in_addr_c ? !gen_first_c
                               : ((state_q == ST_LASTDATA) || (state_q == ST_ERR));
  assign err_c     = dp_c && HRESP;
  assign good_rd_c = dp_c && HREADY && !HRESP && !hwrite_q && !discard_q && (state_q != ST_ERR);
  assign reject_c  = (cmd.addr[1:0] != 2'b00) || gen_cross_c;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q       <= ST_IDLE;
      htrans_q      <= HTRANS_IDLE;
      hwrite_q      <= 1'b0;
      hburst_q      <= HBURST_SINGLE;
      hwdata_q      <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      done_q        <= 1'b0;
      done_err_q    <= 1'b0;
      busy_q        <= 1'b0;
      cmd_ready_q   <= 1'b1;
      discard_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      htrans_q      <= htrans_d;
      hwrite_q      <= hwrite_d;
      hburst_q      <= hburst_d;
      hwdata_q      <= hwdata_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      done_q        <= done_d;
      done_err_q    <= done_err_d;
      busy_q        <= busy_d;
      cmd_ready_q   <= cmd_ready_d;
      discard_q     <= discard_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    htrans_d      = htrans_q;
    hwrite_d      = hwrite_q;
    hburst_d      = hburst_q;
    hwdata_d      = hwdata_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    done_d        = 1'b0;
    done_err_d    = 1'b0;
    discard_d     = discard_q;
    gen_load      = 1'b0;
    gen_adv       = 1'b0;
    wdata_pop_c   = 1'b0;

    if (good_rd_c) begin
      rdata_d       = HRDATA;
      rdata_valid_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (reject_c) begin
            state_d    = ST_REJECT;
            done_d     = 1'b1;
            done_err_d = 1'b1;
          end else begin
            gen_load  = 1'b1;
            htrans_d  = HTRANS_NONSEQ;
            hwrite_d  = cmd.write;
            hburst_d  = len_to_hburst(cmd.len);
            discard_d = 1'b0;
            state_d   = ST_ADDR;
          end
        end
      end
      ST_ADDR, ST_BURST: begin
        if (err_c && !HREADY) begin
          // First cycle of a two-cycle error: withdraw the pending address.
          htrans_d = HTRANS_IDLE;
          state_d  = ST_ERR;
        end else if (HREADY) begin
          if (err_c) begin
            // Address taken alongside a single-cycle error: let it finish, drop its data.
            htrans_d  = HTRANS_IDLE;
            discard_d = 1'b1;
            state_d   = ST_ERR;
          end else begin
            if (hwrite_q) begin
              wdata_pop_c = 1'b1;
              hwdata_d    = wdata;
            end
            if (gen_last_c) begin
              htrans_d = HTRANS_IDLE;
              state_d  = ST_LASTDATA;
            end else begin
              gen_adv  = 1'b1;
              htrans_d = HTRANS_SEQ;
              state_d  = ST_BURST;
            end
          end
        end
      end
      ST_LASTDATA: begin
        if (HREADY) begin
          done_d     = 1'b1;
          done_err_d = HRESP;
          state_d    = ST_IDLE;
        end else if (HRESP) begin
          state_d = ST_ERR;
        end
      end
      ST_ERR: begin
        if (HREADY) begin
          done_d     = 1'b1;
          done_err_d = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      ST_REJECT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d  = ST_IDLE;
        htrans_d = HTRANS_IDLE;
      end
    endcase

    busy_d      = (state_d != ST_IDLE);
    cmd_ready_d = (state_d == ST_IDLE);
  end

  assign wdata_pop   = wdata_pop_c && HRESETn;
  assign cmd_ready   = cmd_ready_q;
  assign busy        = busy_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign done        = done_q;
  assign done_err    = done_err_q;
  assign HADDR       = gen_addr;
  assign HTRANS      = htrans_q;
  assign HWRITE      = hwrite_q;
  assign HBURST      = hburst_q;
  assign HWDATA      = hwdata_q;
  assign HSIZE       = HSIZE_WORD;
  assign HPROT       = HPROT_VAL;
  assign HMASTLOCK   = LOCKED;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed bench for ahb_lite_master: the bench plays the slave cycle by cycle.
module tb_ahb_lite_master;
  import ahb_pkg::*;

  logic        HCLK;
  logic        HRESETn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [1:0]  cmd_len;
  logic [31:0] wdata, rdata;
  logic        wdata_pop, rdata_valid, done, done_err, busy;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [2:0]  HBURST, HSIZE;
  logic        HMASTLOCK, HWRITE, HREADY, HRESP;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;

  int vecs = 0;
  int miss = 0;

  ahb_lite_master dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_write(cmd_write), .cmd_len(cmd_len),
    .wdata(wdata), .wdata_pop(wdata_pop),
    .rdata(rdata), .rdata_valid(rdata_valid),
    .done(done), .done_err(done_err), .busy(busy),
    .HADDR(HADDR), .HBURST(HBURST), .HMASTLOCK(HMASTLOCK), .HPROT(HPROT),
    .HSIZE(HSIZE), .HTRANS(HTRANS), .HWRITE(HWRITE), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Inputs change 1ns after the rising edge; outputs are sampled 4ns later.
  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic test_reset();
    HRESETn = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_write = 1'b0; cmd_len = 2'b00;
    wdata = '0; HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0;
    tick(); tick(); #4;
    vecs++;
    if ({HTRANS, HBURST, HSIZE, HWRITE, HPROT, HMASTLOCK} !== {2'b00, 3'b000, 3'b010, 1'b0, 4'b0011, 1'b0}) begin
      miss++; $display("FAIL reset_bus got %h want %h", {HTRANS, HBURST, HSIZE, HWRITE, HPROT, HMASTLOCK},
                       {2'b00, 3'b000, 3'b010, 1'b0, 4'b0011, 1'b0});
    end
    vecs++;
    if ({HADDR, HWDATA, rdata} !== 96'd0) begin
      miss++; $display("FAIL reset_data got HADDR=%h HWDATA=%h rdata=%h want 0", HADDR, HWDATA, rdata);
    end
    vecs++;
    if ({cmd_ready, busy, rdata_valid, done, done_err, wdata_pop} !== 6'b100000) begin
      miss++; $display("FAIL reset_ctrl got %b want 100000", {cmd_ready, busy, rdata_valid, done, done_err, wdata_pop});
    end
    tick();
    HRESETn = 1'b1;
    tick();
  endtask

  task automatic test_single_read(input logic [31:0] a, input logic [31:0] d);
    cmd_valid = 1'b1; cmd_addr = a; cmd_write = 1'b0; cmd_len = 2'b00; HREADY = 1'b1; HRESP = 1'b0;
    #4;
    vecs++;
    if (cmd_ready !== 1'b1) begin miss++; $display("FAIL single_ready got %b want 1", cmd_ready); end
    tick(); cmd_valid = 1'b0; #4;
    vecs++;
    if ({HTRANS, HADDR, HBURST, HWRITE} !== {HTRANS_NONSEQ, a, HBURST_SINGLE, 1'b0}) begin
      miss++; $display("FAIL single_t1 got %h want %h", {HTRANS, HADDR, HBURST, HWRITE}, {HTRANS_NONSEQ, a, HBURST_SINGLE, 1'b0});
    end
    tick(); HRDATA = d; #4;
    vecs++;
    if ({HTRANS, rdata_valid, done} !== {HTRANS_IDLE, 2'b00}) begin
      miss++; $display("FAIL single_t2 got %b want 0000", {HTRANS, rdata_valid, done});
    end
    tick(); HRDATA = 32'h0; #4;
    vecs++;
    if ({rdata, rdata_valid, done, done_err} !== {d, 3'b110}) begin
      miss++; $display("FAIL single_t3 got rdata=%h rv/done/err=%b want %h 110", rdata, {rdata_valid, done, done_err}, d);
    end
    tick(); #4;
    vecs++;
    if ({rdata_valid, done, cmd_ready, busy} !== 4'b0010) begin
      miss++; $display("FAIL single_t4 got %b want 0010", {rdata_valid, done, cmd_ready, busy});
    end
    tick();
  endtask

  task automatic test_incr4_stall();
    logic        rdy [1:8];
    logic [1:0]  etr [1:8];
    logic [31:0] ead [1:8];
    logic [31:0] hrd [1:8];
    logic        erv [1:8];
    logic [31:0] erd [1:8];
    logic        edn [1:8];
    rdy = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    etr = '{HTRANS_NONSEQ, HTRANS_SEQ, HTRANS_SEQ, HTRANS_SEQ, HTRANS_SEQ, HTRANS_SEQ, HTRANS_IDLE, HTRANS_IDLE};
    ead = '{32'h10, 32'h14, 32'h18, 32'h18, 32'h18, 32'h1C, 32'h0, 32'h0};
    hrd = '{32'h0, 32'hA110_0010, 32'hBAD0_BAD0, 32'hBAD1_BAD1, 32'hA220_0014, 32'hA330_0018, 32'hA440_001C, 32'h0};
    erv = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    erd = '{32'h0, 32'h0, 32'hA110_0010, 32'h0, 32'h0, 32'hA220_0014, 32'hA330_0018, 32'hA440_001C};
    edn = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    cmd_valid = 1'b1; cmd_addr = 32'h10; cmd_write = 1'b0; cmd_len = 2'b01;
    #4; tick(); cmd_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      HREADY = rdy[c]; HRDATA = hrd[c]; #4;
      vecs++;
      if (HTRANS !== etr[c] || (etr[c] != HTRANS_IDLE && (HADDR !== ead[c] || HBURST !== HBURST_INCR4))) begin
        miss++; $display("FAIL incr4_addr c%0d got HTRANS=%h HADDR=%h HBURST=%h want %h %h %h",
                         c, HTRANS, HADDR, HBURST, etr[c], ead[c], HBURST_INCR4);
      end
      vecs++;
      if (rdata_valid !== erv[c] || (erv[c] && rdata !== erd[c]) || done !== edn[c] || done_err !== 1'b0) begin
        miss++; $display("FAIL incr4_data c%0d got rv=%b rdata=%h done=%b err=%b want rv=%b rdata=%h done=%b err=0",
                         c, rdata_valid, rdata, done, done_err, erv[c], erd[c], edn[c]);
      end
      tick();
    end
    HREADY = 1'b1; HRDATA = 32'h0; #4;
    vecs++;
    if ({done, rdata_valid, cmd_ready} !== 3'b001) begin
      miss++; $display("FAIL incr4_end got %b want 001", {done, rdata_valid, cmd_ready});
    end
    tick();
  endtask

  task automatic test_write_err_single();
    int pops = 0;
    wdata = 32'hCAFE_F00D;
    cmd_valid = 1'b1; cmd_addr = 32'h40; cmd_write = 1'b1; cmd_len = 2'b00; HREADY = 1'b1; HRESP = 1'b0;
    #4; tick(); cmd_valid = 1'b0; #4;
    vecs++;
    if ({HTRANS, HWRITE, wdata_pop} !== {HTRANS_NONSEQ, 2'b11}) begin
      miss++; $display("FAIL wr1_t1 got %b want 1011", {HTRANS, HWRITE, wdata_pop});
    end
    if (wdata_pop) pops++;
    tick(); HRESP = 1'b1; #4;
    vecs++;
    if ({HTRANS, HWDATA, wdata_pop, done} !== {HTRANS_IDLE, 32'hCAFE_F00D, 2'b00}) begin
      miss++; $display("FAIL wr1_t2 got HTRANS=%h HWDATA=%h pop=%b done=%b want 0 cafef00d 0 0", HTRANS, HWDATA, wdata_pop, done);
    end
    if (wdata_pop) pops++;
    tick(); HRESP = 1'b0; #4;
    vecs++;
    if ({done, done_err, rdata_valid, HTRANS} !== {3'b110, HTRANS_IDLE}) begin
      miss++; $display("FAIL wr1_t3 got %b want 11000", {done, done_err, rdata_valid, HTRANS});
    end
    if (wdata_pop) pops++;
    tick(); #4;
    if (wdata_pop) pops++;
    vecs++;
    if ({done, HTRANS, cmd_ready} !== {1'b0, HTRANS_IDLE, 1'b1} || pops != 1) begin
      miss++; $display("FAIL wr1_t4 got done/htrans/ready=%b pops=%0d want 0001 pops=1", {done, HTRANS, cmd_ready}, pops);
    end
    tick();
  endtask

  task automatic test_write_err_two_cycle();
    logic        rdy [1:6];
    logic        rsp [1:6];
    logic [1:0]  etr [1:6];
    logic [31:0] ead [1:6];
    logic        epop [1:6];
    logic [31:0] ehw [1:6];
    logic        edn [1:6];
    logic [31:0] fifo [0:7];
    int idx = 0;
    int pops = 0;
    rdy  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    rsp  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    etr  = '{HTRANS_NONSEQ, HTRANS_SEQ, HTRANS_SEQ, HTRANS_SEQ, HTRANS_IDLE, HTRANS_IDLE};
    ead  = '{32'h200, 32'h204, 32'h208, 32'h20C, 32'h0, 32'h0};
    epop = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    ehw  = '{32'h0, 32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 32'h0, 32'h0};
    edn  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) fifo[i] = 32'hA000_0000 + 32'(i);
    wdata = fifo[0];
    cmd_valid = 1'b1; cmd_addr = 32'h200; cmd_write = 1'b1; cmd_len = 2'b10; HREADY = 1'b1; HRESP = 1'b0;
    #4; tick();
    cmd_addr = 32'h300;
    for (int c = 1; c <= 6; c++) begin
      cmd_valid = (c <= 4); HREADY = rdy[c]; HRESP = rsp[c]; wdata = fifo[idx]; #4;
      vecs++;
      if (HTRANS !== etr[c] || (etr[c] != HTRANS_IDLE && (HADDR !== ead[c] || HBURST !== HBURST_INCR8 || HWRITE !== 1'b1))) begin
        miss++; $display("FAIL wr8_addr c%0d got HTRANS=%h HADDR=%h HBURST=%h want %h %h %h",
                         c, HTRANS, HADDR, HBURST, etr[c], ead[c], HBURST_INCR8);
      end
      vecs++;
      if (wdata_pop !== epop[c] || (c >= 2 && c <= 4 && HWDATA !== ehw[c]) || done !== edn[c] ||
          (edn[c] && done_err !== 1'b1) || (c <= 4 && cmd_ready !== 1'b0)) begin
        miss++; $display("FAIL wr8_data c%0d got pop=%b HWDATA=%h done=%b err=%b ready=%b want pop=%b HWDATA=%h done=%b",
                         c, wdata_pop, HWDATA, done, done_err, cmd_ready, epop[c], ehw[c], edn[c]);
      end
      if (wdata_pop) begin pops++; idx++; end
      tick();
    end
    HRESP = 1'b0; HREADY = 1'b1; #4;
    vecs++;
    if (pops != 3 || {done, HTRANS, cmd_ready} !== {1'b0, HTRANS_IDLE, 1'b1}) begin
      miss++; $display("FAIL wr8_end got pops=%0d done/htrans/ready=%b want pops=3 0001", pops, {done, HTRANS, cmd_ready});
    end
    tick();
  endtask

  task automatic test_reject();
    logic [31:0] a [0:1];
    logic [1:0]  l [0:1];
    a = '{32'h102, 32'h3F0};
    l = '{2'b00, 2'b11};
    for (int k = 0; k < 2; k++) begin
      cmd_valid = 1'b1; cmd_addr = a[k]; cmd_write = 1'b0; cmd_len = l[k]; HREADY = 1'b1; HRESP = 1'b0;
      #4; tick(); cmd_valid = 1'b0; #4;
      vecs++;
      if ({HTRANS, done, done_err, cmd_ready} !== {HTRANS_IDLE, 3'b110}) begin
        miss++; $display("FAIL reject%0d_t1 got %b want 00110", k, {HTRANS, done, done_err, cmd_ready});
      end
      tick(); #4;
      vecs++;
      if ({HTRANS, done, cmd_ready} !== {HTRANS_IDLE, 2'b01}) begin
        miss++; $display("FAIL reject%0d_t2 got %b want 0001", k, {HTRANS, done, cmd_ready});
      end
      tick();
    end
  endtask

  task automatic test_boundary_ok();
    int rvs = 0;
    cmd_valid = 1'b1; cmd_addr = 32'h3F0; cmd_write = 1'b0; cmd_len = 2'b01; HREADY = 1'b1; HRESP = 1'b0;
    #4; tick(); cmd_valid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      HRDATA = 32'h5000_0000 + 32'(c); #4;
      if (rdata_valid) rvs++;
      if (c == 1) begin
        vecs++;
        if ({HTRANS, HADDR} !== {HTRANS_NONSEQ, 32'h3F0}) begin
          miss++; $display("FAIL edge_t1 got HTRANS=%h HADDR=%h want 2 000003f0", HTRANS, HADDR);
        end
      end
      vecs++;
      if (done !== 1'(c == 6) || (c == 6 && (done_err !== 1'b0 || rdata !== 32'h5000_0005 || rvs != 4))) begin
        miss++; $display("FAIL edge_c%0d got done=%b err=%b rdata=%h rvs=%0d want done=%b err=0 rdata=50000005 rvs=4",
                         c, done, done_err, rdata, rvs, (c == 6));
      end
      tick();
    end
    HRDATA = 32'h0;
  endtask

  task automatic test_reset_mid_burst();
    cmd_valid = 1'b1; cmd_addr = 32'h80; cmd_write = 1'b0; cmd_len = 2'b10; HREADY = 1'b1; HRESP = 1'b0;
    #4; tick(); cmd_valid = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      HRDATA = 32'h7000_0000 + 32'(c);
      if (c == 5) HRESETn = 1'b0;
      #4;
      if (c == 5) begin
        vecs++;
        if ({HTRANS, HADDR} !== {HTRANS_SEQ, 32'h90}) begin
          miss++; $display("FAIL rst_beat5 got HTRANS=%h HADDR=%h want 3 00000090", HTRANS, HADDR);
        end
      end
      tick();
    end
    HRESETn = 1'b1; HRDATA = 32'h0; #4;
    vecs++;
    if ({HTRANS, cmd_ready, busy, done, rdata_valid} !== {HTRANS_IDLE, 4'b1000} || HADDR !== 32'h0 || rdata !== 32'h0) begin
      miss++; $display("FAIL rst_after got ctrl=%b HADDR=%h rdata=%h want 001000 0 0", {HTRANS, cmd_ready, busy, done, rdata_valid}, HADDR, rdata);
    end
    tick();
    for (int c = 0; c < 3; c++) begin
      #4;
      vecs++;
      if ({done, HTRANS} !== 3'b000) begin
        miss++; $display("FAIL rst_quiet%0d got done/htrans=%b want 000", c, {done, HTRANS});
      end
      tick();
    end
    test_single_read(32'h20, 32'h600D_F00D);
  endtask

  initial begin
    test_reset();
    test_single_read(32'h100, 32'hDEAD_BEEF);
    test_incr4_stall();
    test_write_err_single();
    test_write_err_two_cycle();
    test_reject();
    test_boundary_ok();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
